// File: rtl/i2c_master_bit_controller_pkg.sv
// i2c_master_bit_controller_pkg: command codes shared by the bit and byte controllers
package i2c_master_bit_controller_pkg;
  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;
endpackage

// File: rtl/i2c_master_bit_controller_prescaler.sv
// i2c_master_bit_controller_prescaler: SCL phase timer with slave stretch hold and multi-master clock sync
module i2c_master_bit_controller_prescaler (
  input  logic        clk,
  input  logic        nReset,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] clk_cnt,
  input  logic        scl_oen,
  input  logic        sSCL,
  input  logic        dSCL,
  output logic        clk_en
);
  logic [15:0] cnt;
  logic dscl_oen, slave_wait, scl_sync;
  assign scl_sync = dSCL & ~sSCL & scl_oen;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      dscl_oen <= 1'b1;
      slave_wait <= 1'b0;
    end else if (rst) begin
      dscl_oen <= 1'b1;
      slave_wait <= 1'b0;
    end else begin
      dscl_oen <= scl_oen;
      slave_wait <= (scl_oen & ~dscl_oen & ~sSCL) | (slave_wait & ~sSCL);
    end
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      cnt <= '0;
      clk_en <= 1'b0;
    end else if (rst) begin
      cnt <= '0;
      clk_en <= 1'b0;
    end else if (!ena) begin
      cnt <= clk_cnt;
      clk_en <= 1'b0;
    end else if (slave_wait) begin
      clk_en <= 1'b0;
    end else if (cnt == 16'd0 || scl_sync) begin
      cnt <= clk_cnt;
      clk_en <= 1'b1;
    end else begin
      cnt <= cnt - 16'd1;
      clk_en <= 1'b0;
    end
endmodule

// File: rtl/i2c_master_bit_controller.sv
// i2c_master_bit_controller: bit-level I2C master executing one START/STOP/WRITE/READ primitive per command
module i2c_master_bit_controller
  import i2c_master_bit_controller_pkg::*;
(
  input  logic        clk,
  input  logic        nReset,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] clk_cnt,
  input  logic [3:0]  cmd,
  output logic        cmd_ack,
  output logic        busy,
  output logic        al,
  input  logic        din,
  output logic        dout,
  input  logic        scl_i,
  output logic        scl_o,
  output logic        scl_oen,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen
);
  typedef enum logic [4:0] {
    idle, start_a, start_b, start_c, start_d, start_e,
    stop_a, stop_b, stop_c, stop_d,
    rd_a, rd_b, rd_c, rd_d,
    wr_a, wr_b, wr_c, wr_d
  } state_t;
  state_t state, nxt;
  logic [1:0] s1;
  logic sSCL, sSDA, dSCL, dSDA, clk_en, sda_chk, cmd_stop;
  logic sta_condition, sto_condition, ack_nxt, scl_nxt, sda_nxt;
  assign scl_o = 1'b0;
  assign sda_o = 1'b0;
  assign sta_condition = ~sSDA & dSDA & sSCL;
  assign sto_condition = sSDA & ~dSDA & sSCL;
  i2c_master_bit_controller_prescaler u_prescaler (
    .clk(clk), .nReset(nReset), .rst(rst), .ena(ena), .clk_cnt(clk_cnt),
    .scl_oen(scl_oen), .sSCL(sSCL), .dSCL(dSCL), .clk_en(clk_en)
  );
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      {s1, sSCL, sSDA, dSCL, dSDA} <= '1;
      {busy, al, dout, cmd_stop} <= '0;
    end else if (rst) begin
      {s1, sSCL, sSDA, dSCL, dSDA} <= '1;
      {busy, al, dout, cmd_stop} <= '0;
    end else begin
      s1 <= {scl_i, sda_i};
      {sSCL, sSDA} <= s1;
      {dSCL, dSDA} <= {sSCL, sSDA};
      busy <= (sta_condition | busy) & ~sto_condition;
      // gated by ~al so one loss event yields a single pulse while the FSM unwinds
      al <= ~al & ((sda_chk & ~sSDA & sda_oen) | ((state != idle) & sto_condition & ~cmd_stop));
      if (sSCL & ~dSCL) dout <= sSDA;
      if (clk_en) cmd_stop <= cmd == I2C_CMD_STOP;
    end
  always_comb begin
    nxt = state;
    ack_nxt = 1'b0;
    case (state)
      idle:    nxt = cmd == I2C_CMD_START ? start_a :
                     cmd == I2C_CMD_STOP  ? stop_a  :
                     cmd == I2C_CMD_WRITE ? wr_a    :
                     cmd == I2C_CMD_READ  ? rd_a    : idle;
      start_a: nxt = start_b;
      start_b: nxt = start_c;
      start_c: nxt = start_d;
      start_d: nxt = start_e;
      stop_a:  nxt = stop_b;
      stop_b:  nxt = stop_c;
      stop_c:  nxt = stop_d;
      rd_a:    nxt = rd_b;
      rd_b:    nxt = rd_c;
      rd_c:    nxt = rd_d;
      wr_a:    nxt = wr_b;
      wr_b:    nxt = wr_c;
      wr_c:    nxt = wr_d;
      start_e, stop_d, rd_d, wr_d: begin
        nxt = idle;
        ack_nxt = 1'b1;
      end
      default: nxt = idle;
    endcase
    scl_nxt = scl_oen;
    sda_nxt = sda_oen;
    case (nxt)
      start_a:                         sda_nxt = 1'b1;
      start_b, stop_d, rd_b, rd_c:     {scl_nxt, sda_nxt} = 2'b11;
      start_c, start_d, stop_b, stop_c: {scl_nxt, sda_nxt} = 2'b10;
      start_e, stop_a:                 {scl_nxt, sda_nxt} = 2'b00;
      rd_a, rd_d:                      {scl_nxt, sda_nxt} = 2'b01;
      wr_a, wr_d:                      {scl_nxt, sda_nxt} = {1'b0, din};
      wr_b, wr_c:                      {scl_nxt, sda_nxt} = {1'b1, din};
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state <= idle;
      {scl_oen, sda_oen, cmd_ack, sda_chk} <= 4'b1100;
    end else if (rst || al) begin
      state <= idle;
      {scl_oen, sda_oen, cmd_ack, sda_chk} <= 4'b1100;
    end else begin
      cmd_ack <= clk_en & ack_nxt;
      if (clk_en) begin
        state <= nxt;
        scl_oen <= scl_nxt;
        sda_oen <= sda_nxt;
        sda_chk <= nxt == wr_c;
      end
    end
endmodule

// File: tb/tb_i2c_master_bit_controller.sv
// tb_i2c_master_bit_controller: directed self-checking bench with an open-drain bus model
module tb_i2c_master_bit_controller;
  import i2c_master_bit_controller_pkg::*;
  logic clk = 1'b0, nReset = 1'b0, rst = 1'b0, ena = 1'b0, din = 1'b0;
  logic [15:0] clk_cnt = 16'd4;
  logic [3:0] cmd = I2C_CMD_NOP;
  logic cmd_ack, busy, al, dout, scl_o, sda_o, scl_oen, sda_oen, scl_i, sda_i;
  logic scl_hold = 1'b0, sda_hold = 1'b0;
  int n_assert = 0, n_fail = 0;
  assign scl_i = scl_oen & ~scl_hold;
  assign sda_i = sda_oen & ~sda_hold;
  always #5 clk = ~clk;
  i2c_master_bit_controller dut (
    .clk(clk), .nReset(nReset), .rst(rst), .ena(ena), .clk_cnt(clk_cnt),
    .cmd(cmd), .cmd_ack(cmd_ack), .busy(busy), .al(al), .din(din), .dout(dout),
    .scl_i(scl_i), .scl_o(scl_o), .scl_oen(scl_oen),
    .sda_i(sda_i), .sda_o(sda_o), .sda_oen(sda_oen)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic run_write(input logic b);
    int n, rises, bad;
    logic p_scl, seen;
    din = b;
    cmd = I2C_CMD_WRITE;
    n = 0; rises = 0; bad = 0; seen = 1'b0; p_scl = scl_oen;
    while (!seen && n < 200) begin
      tick(); n++;
      if (!p_scl && scl_oen) rises++;
      if (scl_oen && sda_oen !== b) bad++;
      if (al) bad++;
      p_scl = scl_oen;
      seen = cmd_ack;
    end
    cmd = I2C_CMD_NOP;
    check($sformatf("wr%0d_ack", b), seen, 1);
    check_range($sformatf("wr%0d_latency", b), n, 23, 27);
    check($sformatf("wr%0d_scl_pulses", b), rises, 1);
    check($sformatf("wr%0d_sda_stable_al", b), bad, 0);
    check($sformatf("wr%0d_dout", b), dout, b);
    check($sformatf("wr%0d_end_lines", b), {scl_oen, sda_oen}, {1'b0, b});
  endtask
  initial begin
    int n, bad, t_sda, t_scl, t_busy, t_rise, t_fall, t_al, al_n, ack_n;
    logic p_sda, p_scl, p_busy, seen;
    repeat (3) tick();
    nReset = 1'b1;
    ena = 1'b1;
    tick();
    check("rst_scl_oen", scl_oen, 1);
    check("rst_sda_oen", sda_oen, 1);
    check("rst_busy", busy, 0);
    check("rst_al", al, 0);
    check("rst_cmd_ack", cmd_ack, 0);
    check("rst_dout", dout, 0);
    check("od_outputs", {scl_o, sda_o}, 0);
    bad = 0;
    repeat (100) begin
      tick();
      if ({scl_oen, sda_oen, busy, al, cmd_ack, dout} !== 6'b110000) bad++;
    end
    check("nop_stable", bad, 0);
    cmd = I2C_CMD_START;
    n = 0; bad = 0; t_sda = -1; t_scl = -1; t_busy = -1; seen = 1'b0;
    p_sda = sda_oen; p_scl = scl_oen; p_busy = busy;
    while (!seen && n < 100) begin
      tick(); n++;
      if (p_sda && !sda_oen && t_sda < 0) begin
        t_sda = n;
        if (!scl_oen) bad++;
      end
      if (p_scl && !scl_oen && t_scl < 0) t_scl = n;
      if (!p_busy && busy && t_busy < 0) t_busy = n;
      if (al) bad++;
      p_sda = sda_oen; p_scl = scl_oen; p_busy = busy;
      seen = cmd_ack;
    end
    cmd = I2C_CMD_NOP;
    check("start_ack", seen, 1);
    check_range("start_latency", n, 26, 30);
    check("start_sda_before_scl", t_sda > 0 && t_scl > t_sda, 1);
    check("start_busy_lag", t_busy - t_sda, 3);
    check("start_scl_high_no_al", bad, 0);
    check("start_end_lines", {scl_oen, sda_oen}, 2'b00);
    tick();
    check("start_ack_pulse", cmd_ack, 0);
    run_write(1'b0);
    run_write(1'b1);
    sda_hold = 1'b1;
    cmd = I2C_CMD_READ;
    n = 0; seen = 1'b0; t_rise = -1; t_fall = -1; p_scl = scl_oen;
    while (!seen && n < 300) begin
      tick(); n++;
      if (!p_scl && scl_oen && t_rise < 0) begin
        t_rise = n;
        scl_hold = 1'b1;
      end
      if (t_rise > 0 && n == t_rise + 50) scl_hold = 1'b0;
      if (p_scl && !scl_oen && t_rise > 0 && t_fall < 0) t_fall = n;
      p_scl = scl_oen;
      seen = cmd_ack;
    end
    cmd = I2C_CMD_NOP;
    scl_hold = 1'b0;
    check("rd_ack", seen, 1);
    check_range("rd_stretch_high", t_fall - t_rise, 60, 64);
    check("rd_dout", dout, 0);
    check("rd_end_lines", {scl_oen, sda_oen}, 2'b01);
    sda_hold = 1'b0;
    din = 1'b1;
    cmd = I2C_CMD_WRITE;
    t_al = -1; al_n = 0; ack_n = 0; bad = 0; p_scl = scl_oen;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!p_scl && scl_oen && t_al < 0) sda_hold = 1'b1;
      if (al) begin
        al_n++;
        if (t_al < 0) begin
          t_al = i;
          cmd = I2C_CMD_NOP;
        end
      end
      if (cmd_ack) ack_n++;
      if (t_al > 0 && i == t_al + 1) begin
        if ({scl_oen, sda_oen} !== 2'b11) bad++;
        sda_hold = 1'b0;
      end
      p_scl = scl_oen;
    end
    check("arb_al_seen", t_al > 0, 1);
    check("arb_al_pulses", al_n, 1);
    check("arb_no_ack", ack_n, 0);
    check("arb_lines_released", bad, 0);
    check("arb_bus_free", busy, 0);
    ena = 1'b0;
    cmd = I2C_CMD_START;
    bad = 0;
    repeat (40) begin
      tick();
      if (cmd_ack || {scl_oen, sda_oen} !== 2'b11) bad++;
    end
    cmd = I2C_CMD_NOP;
    ena = 1'b1;
    check("ena_freeze", bad, 0);
    cmd = I2C_CMD_START;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      tick(); n++;
      seen = cmd_ack;
    end
    cmd = I2C_CMD_NOP;
    check("start2_ack", seen, 1);
    check("start2_busy", busy, 1);
    cmd = I2C_CMD_STOP;
    n = 0; seen = 1'b0; bad = 0; t_rise = -1; p_sda = sda_oen;
    while (!seen && n < 100) begin
      tick(); n++;
      if (!p_sda && sda_oen && t_rise < 0) begin
        t_rise = n;
        if (!scl_oen) bad++;
      end
      if (al) bad++;
      p_sda = sda_oen;
      seen = cmd_ack;
    end
    cmd = I2C_CMD_NOP;
    check("stop_ack", seen, 1);
    check_range("stop_latency", n, 23, 27);
    check("stop_sda_rise_seen", t_rise > 0, 1);
    check("stop_scl_high_no_al", bad, 0);
    check("stop_busy", busy, 0);
    check("stop_end_lines", {scl_oen, sda_oen}, 2'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
